// File: rtl/universal_shift_reg_nbit.sv
// Universal shift register: DEPTH lanes of WIDTH bits with hold, shift right,
// shift left and parallel load; each lane carries a valid bit feeding fill/full.
module universal_shift_reg_nbit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int FW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_ah_in,
    input  logic                   clear_in,
    input  logic                   en_in,
    input  logic [1:0]             mode_in,
    input  logic [WIDTH-1:0]       sr_in,
    input  logic [WIDTH-1:0]       sl_in,
    input  logic [DEPTH*WIDTH-1:0] par_in,
    output logic [DEPTH*WIDTH-1:0] par_out,
    output logic [WIDTH-1:0]       sr_out,
    output logic [WIDTH-1:0]       sl_out,
    output logic                   sr_valid_out,
    output logic                   sl_valid_out,
    output logic [FW-1:0]          fill_out,
    output logic                   full_out
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [DEPTH*WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [FW-1:0]          fill_cnt;

    // Stage i lives at data_q[i*WIDTH +: WIDTH]; right shift moves toward stage 0.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en_in) begin
            case (mode_in)
                MODE_RIGHT: begin
                    data_d  = {sr_in, data_q[DEPTH*WIDTH-1:WIDTH]};
                    valid_d = {1'b1, valid_q[DEPTH-1:1]};
                end
                MODE_LEFT: begin
                    data_d  = {data_q[(DEPTH-1)*WIDTH-1:0], sl_in};
                    valid_d = {valid_q[DEPTH-2:0], 1'b1};
                end
                MODE_LOAD: begin
                    data_d  = par_in;
                    valid_d = '1;
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_ah_in || clear_in) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        fill_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fill_cnt = fill_cnt + FW'(valid_q[i]);
        end
    end

    assign par_out      = data_q;
    assign sr_out       = data_q[WIDTH-1:0];
    assign sl_out       = data_q[DEPTH*WIDTH-1:(DEPTH-1)*WIDTH];
    assign sr_valid_out = valid_q[0];
    assign sl_valid_out = valid_q[DEPTH-1];
    assign fill_out     = fill_cnt;
    assign full_out     = (fill_cnt == FW'(DEPTH));

endmodule
